// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder datapath, the sum accumulator and its consumer.
interface sum_accumulator_if #(
   parameter int IN_W  = 4,
   parameter int ACC_W = 8
);
   logic [IN_W-1:0]  in_s;
   logic             in_c;
   logic             in_valid;
   logic             in_ready;
   logic             clr;
   logic [ACC_W-1:0] out_sum;
   logic             out_ovf;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_s, in_c, in_valid, clr, out_ready,
      input  in_ready, out_sum, out_ovf, out_valid
   );

   modport slave (
      input  in_s, in_c, in_valid, clr, out_ready,
      output in_ready, out_sum, out_ovf, out_valid
   );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT {carry,sum} samples into an ACC_W-bit total with sticky overflow.
// Optional SUM_ACC_SAT_EN: clamp the total to all-ones on overflow instead of wrapping.
module sum_accumulator #(
   parameter int IN_W  = 4,
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input logic              clk,
   input logic              rst,
   sum_accumulator_if.slave bus
);
   typedef enum logic {ST_ACC, ST_DONE} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [7:0]       cnt, cnt_nxt;
   logic             ovf, ovf_nxt;
   logic [ACC_W-1:0] smp;
   logic [ACC_W:0]   sum_ext;

   assign smp     = ACC_W'({bus.in_c, bus.in_s});
   assign sum_ext = {1'b0, acc} + {1'b0, smp};

   // The accumulator register doubles as the result; it is frozen while in DONE.
   assign bus.in_ready  = (state == ST_ACC) & ~bus.clr;
   assign bus.out_valid = (state == ST_DONE);
   assign bus.out_sum   = acc;
   assign bus.out_ovf   = ovf;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_ACC;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      if (bus.clr) begin
         state_nxt = ST_ACC;
         acc_nxt   = '0;
         cnt_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else begin
         unique case (state)
            ST_ACC: begin
               if (bus.in_valid) begin
                  cnt_nxt = cnt + 8'd1;
                  ovf_nxt = ovf | sum_ext[ACC_W];
`ifdef SUM_ACC_SAT_EN
                  acc_nxt = (ovf | sum_ext[ACC_W]) ? '1 : sum_ext[ACC_W-1:0];
`else
                  acc_nxt = sum_ext[ACC_W-1:0];
`endif
                  if (cnt == 8'(COUNT - 1)) state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state_nxt = ST_ACC;
                  acc_nxt   = '0;
                  cnt_nxt   = '0;
                  ovf_nxt   = 1'b0;
               end
            end
            default: state_nxt = ST_ACC;
         endcase
      end
   end
endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench: two accumulators (COUNT=4 and COUNT=9) share stimulus; a
// window-total model pushes expected results, per-instance monitors pop on handshake.
module tb_sum_accumulator;
   localparam int IN_W  = 4;
   localparam int ACC_W = 8;
   localparam int CNT0  = 4;
   localparam int CNT1  = 9;
   localparam int MAXV  = (1 << ACC_W) - 1;

   typedef logic [ACC_W:0] exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) b0 ();
   sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) b1 ();

   sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT(CNT0)) dut0 (
      .clk(clk), .rst(rst), .bus(b0.slave));
   sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT(CNT1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1.slave));

   int   compared   = 0;
   int   mismatched = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   total[2];
   int   n[2];
   bit   pending[2];

   task automatic chk(input string name, input int k, input int act, input int expv);
      compared++;
      if (act != expv) begin
         mismatched++;
         $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", name, k, $time, act, expv);
      end
   endtask

   function automatic int cnt_of(input int k);
      return (k == 0) ? CNT0 : CNT1;
   endfunction

   function automatic int rd_ready(input int k);
      return (k == 0) ? int'(b0.in_ready) : int'(b1.in_ready);
   endfunction
   function automatic int rd_valid(input int k);
      return (k == 0) ? int'(b0.out_valid) : int'(b1.out_valid);
   endfunction
   function automatic int rd_sum(input int k);
      return (k == 0) ? int'(b0.out_sum) : int'(b1.out_sum);
   endfunction
   function automatic int rd_ovf(input int k);
      return (k == 0) ? int'(b0.out_ovf) : int'(b1.out_ovf);
   endfunction

   function automatic int q_size(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction
   function automatic exp_t q_front(input int k);
      return (k == 0) ? q0[0] : q1[0];
   endfunction
   task automatic q_push(input int k, input exp_t e);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
   endtask
   task automatic q_drop_last(input int k);
      if (k == 0) void'(q0.pop_back()); else void'(q1.pop_back());
   endtask

   task automatic drive(input bit v, input bit c, input logic [IN_W-1:0] s,
                        input bit cl, input bit ordy);
      b0.in_valid = v;  b0.in_c = c;  b0.in_s = s;  b0.clr = cl;  b0.out_ready = ordy;
      b1.in_valid = v;  b1.in_c = c;  b1.in_s = s;  b1.clr = cl;  b1.out_ready = ordy;
   endtask

   task automatic model_clear(input int k);
      if (pending[k]) q_drop_last(k);
      total[k] = 0; n[k] = 0; pending[k] = 1'b0;
   endtask

   // Window model: the result is the plain integer total of COUNT samples,
   // reduced to ACC_W bits (wrap or clamp) with overflow = total exceeded the range.
   task automatic model_step(input int k, input bit v, input bit c,
                             input logic [IN_W-1:0] s, input bit cl, input bit ordy);
      exp_t e;
      int   r;
      if (cl) begin
         model_clear(k);
      end else if (pending[k]) begin
         if (ordy) begin
            total[k] = 0; n[k] = 0; pending[k] = 1'b0;
         end
      end else if (v) begin
         total[k] += (int'(c) << IN_W) + int'(s);
         n[k]++;
         if (n[k] == cnt_of(k)) begin
            pending[k] = 1'b1;
`ifdef SUM_ACC_SAT_EN
            r = (total[k] > MAXV) ? MAXV : total[k];
`else
            r = total[k] % (MAXV + 1);
`endif
            e = {(total[k] > MAXV), r[ACC_W-1:0]};
            q_push(k, e);
         end
      end
   endtask

   // Called just after a rising edge; drives one cycle and advances the model.
   task automatic cycle(input bit v, input bit c, input logic [IN_W-1:0] s,
                        input bit cl, input bit ordy);
      exp_t e;
      drive(v, c, s, cl, ordy);
      #3;
      for (int k = 0; k < 2; k++) begin
         chk("in_ready", k, rd_ready(k), int'(!pending[k] && !cl));
         chk("out_valid", k, rd_valid(k), int'(pending[k]));
         if (pending[k] && q_size(k) > 0) begin
            e = q_front(k);
            chk("held_sum", k, rd_sum(k), int'(e[ACC_W-1:0]));
            chk("held_ovf", k, rd_ovf(k), int'(e[ACC_W]));
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) model_step(k, v, c, s, cl, ordy);
   endtask

   // Asserts reset mid-cycle and checks outputs clear without waiting for a clock.
   task automatic do_reset();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_sum", k, rd_sum(k), 0);
         chk("rst_ovf", k, rd_ovf(k), 0);
         chk("rst_valid", k, rd_valid(k), 0);
         model_clear(k);
      end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   exp_t m0, m1;
   always @(negedge clk) begin
      if (rst && b0.out_valid && b0.out_ready && !b0.clr) begin
         if (q0.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL result[0] @%0t: got unexpected result %0h, expected none", $time, b0.out_sum);
         end else begin
            m0 = q0.pop_front();
            chk("result_sum", 0, int'(b0.out_sum), int'(m0[ACC_W-1:0]));
            chk("result_ovf", 0, int'(b0.out_ovf), int'(m0[ACC_W]));
         end
      end
   end
   always @(negedge clk) begin
      if (rst && b1.out_valid && b1.out_ready && !b1.clr) begin
         if (q1.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL result[1] @%0t: got unexpected result %0h, expected none", $time, b1.out_sum);
         end else begin
            m1 = q1.pop_front();
            chk("result_sum", 1, int'(b1.out_sum), int'(m1[ACC_W-1:0]));
            chk("result_ovf", 1, int'(b1.out_ovf), int'(m1[ACC_W]));
         end
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         total[k] = 0; n[k] = 0; pending[k] = 1'b0;
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      do_reset();

      // Four mixed samples: 3 + 5 + 18 + 15 = 41 for the COUNT=4 instance.
      cycle(1, 0, 4'd3, 0, 1);
      cycle(1, 0, 4'd5, 0, 1);
      cycle(1, 1, 4'd2, 0, 1);
      cycle(1, 0, 4'd15, 0, 1);
      repeat (3) cycle(0, 0, '0, 0, 1);

      // Nine samples of 31: COUNT=9 overflows; COUNT=4 holds its result meanwhile.
      do_reset();
      repeat (9) cycle(1, 1, 4'd15, 0, 0);
      repeat (3) cycle(0, 0, '0, 0, 1);

      // Held result with in_valid pulses, then released.
      do_reset();
      repeat (4) cycle(1, 0, 4'd9, 0, 0);
      repeat (5) cycle($urandom_range(0, 1), 0, 4'd1, 0, 0);
      repeat (2) cycle(0, 0, '0, 0, 1);

      // Clear mid-window discards earlier samples.
      do_reset();
      repeat (2) cycle(1, 0, 4'd7, 0, 1);
      cycle(1, 0, 4'd7, 1, 1);
      repeat (4) cycle(1, 0, 4'd1, 0, 0);
      repeat (3) cycle(0, 0, '0, 0, 1);

      // Reset partway through a window.
      do_reset();
      repeat (3) cycle(1, 0, 4'd2, 0, 1);
      do_reset();
      repeat (4) cycle(1, 0, 4'd2, 0, 0);
      repeat (3) cycle(0, 0, '0, 0, 1);

      // Randomized traffic with occasional clears and one mid-run reset.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         cycle(($urandom % 10) < 7, $urandom_range(0, 1), 4'($urandom),
               ($urandom % 20) == 0, $urandom_range(0, 1));
      end
      repeat (12) cycle(0, 0, '0, 0, 1);

      for (int k = 0; k < 2; k++) chk("left_in_queue", k, q_size(k), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
